// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit beside EX:
// op encodings, sequencer states and the default operand width.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] MD_MUL   = 2'b00;
  localparam logic [1:0] MD_MULHU = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_REMU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_iter_dp.sv
// One-bit-per-cycle datapath: shift-add multiply and restoring divide sharing
// the {hi,lo} register pair (hi = product high / remainder, lo = product low / quotient).
module muldiv_iter_dp
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] opb;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic [XLEN:0]   div_trial;
  logic            div_neg;

  // Multiply keeps the adder carry as bit XLEN so it shifts into hi's MSB.
  assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});

  // The remainder stays below the divisor, so an XLEN+1-bit trial carries a valid sign.
  assign div_sh    = {hi, lo[XLEN-1]};
  assign div_trial = div_sh - {1'b0, opb};
  assign div_neg   = div_trial[XLEN];

  always_comb begin
    hi_nxt = mul_sum[XLEN:1];
    lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
    if (is_div) begin
      hi_nxt = div_neg ? div_sh[XLEN-1:0] : div_trial[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], ~div_neg};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi  <= '0;
      lo  <= '0;
      opb <= '0;
    end else if (load) begin
      hi  <= '0;
      lo  <= rs1;
      opb <= rs2;
    end else if (step) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// M-extension sequencer: accepts one op from ID/EX, stalls the pipeline for XLEN
// iterations and releases it in the cycle the registered result is valid.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  state_e          state;
  logic [CNT_W-1:0] count;
  logic [1:0]      op_q;
  logic            accept;
  logic            step;
  logic            last;
  logic [XLEN-1:0] hi_nxt;
  logic [XLEN-1:0] lo_nxt;

  function automatic logic [XLEN-1:0] sel_result(input logic [1:0]      o,
                                                 input logic [XLEN-1:0] hi,
                                                 input logic [XLEN-1:0] lo);
    case (o)
      MD_MULHU, MD_REMU: sel_result = hi;
      default:           sel_result = lo;
    endcase
  endfunction

  assign accept = start & ~flush & (state != RUN);
  assign step   = (state == RUN) & ~flush;
  assign last   = (count == CNT_W'(XLEN - 1));
  // DONE with no new start leaves stall low, releasing the pipeline with the result.
  assign stall  = ~flush & ((start & (state != RUN)) | (state == RUN));

  muldiv_iter_dp #(.XLEN(XLEN)) u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (step),
    .is_div (op_q[1]),
    .rs1    (rs1),
    .rs2    (rs2),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      op_q   <= MD_MUL;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          count <= count + 1'b1;
          if (last) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= sel_result(op_q, hi_nxt, lo_nxt);
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            op_q  <= op;
            count <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed products/quotients, latency,
// stall window, back-to-back start, divide by zero, flush and async reset.
module tb_muldiv_seq;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents an op at the current time and follows it until done (bounded);
  // returns in the DONE cycle, one time unit after the edge that raised done.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n = 0;
    int stall_cnt = 0;
    logic got = 1'b0;
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    #1;
    while (!got && n < 40) begin
      if (stall) stall_cnt++;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      got = done;
    end
    check({tag, "_lat"}, n, 33);
    check({tag, "_stallcyc"}, stall_cnt, 33);
    check({tag, "_res"}, result, exp);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_stall_rel"}, {31'd0, stall}, 0);
  endtask

  task automatic expect_done_drop(input string tag);
    @(posedge clk); #1;
    check({tag, "_done1cyc"}, {31'd0, done}, 0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; op = OP_MUL; rs1 = '0; rs2 = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_stall", {31'd0, stall}, 0);
    check("rst_result", result, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Basic multiply
    @(negedge clk);
    run_op("mul7x6", OP_MUL, 32'd7, 32'd6, 32'h0000002A);
    expect_done_drop("mul7x6");

    @(negedge clk);
    run_op("mulhu_ff", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    @(negedge clk);
    run_op("mul_ff", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);

    // Divide then back-to-back remainder started in the DONE cycle
    @(negedge clk);
    run_op("divu100_7", OP_DIVU, 32'd100, 32'd7, 32'h0000000E);
    run_op("remu100_7_b2b", OP_REMU, 32'd100, 32'd7, 32'h00000002);

    @(negedge clk);
    run_op("divu_by0", OP_DIVU, 32'h12345678, 32'h0, 32'hFFFFFFFF);
    @(negedge clk);
    run_op("remu_by0", OP_REMU, 32'h12345678, 32'h0, 32'h12345678);

    @(negedge clk);
    run_op("mul_pre_flush", OP_MUL, 32'd7, 32'd6, 32'h0000002A);

    // Flush at RUN count 10: accept edge, then 10 more edges
    @(negedge clk);
    start = 1'b1; op = OP_MULHU; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    check("flush_busy_run", {31'd0, busy}, 1);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush_stall_comb", {31'd0, stall}, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    check("flush_busy", {31'd0, busy}, 0);
    check("flush_stall", {31'd0, stall}, 0);
    check("flush_done", {31'd0, done}, 0);
    check("flush_result", result, 32'h0000002A);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("flush_no_done", seen, 0);

    // Start and flush in the same IDLE cycle: start dropped
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MUL; rs1 = 32'd3; rs2 = 32'd3;
    #1;
    check("sf_stall", {31'd0, stall}, 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1;
    check("sf_busy", {31'd0, busy}, 0);
    check("sf_stall_after", {31'd0, stall}, 0);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    check("pre_rst_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_stall", {31'd0, stall}, 0);
    check("arst_done", {31'd0, done}, 0);
    check("arst_result", result, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_op("post_rst_divu", OP_DIVU, 32'd100, 32'd7, 32'h0000000E);
    expect_done_drop("post_rst_divu");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
